// File: rtl/obstacle_wave_scheduler_if.sv
// Scheduler-side bundle between the random/bank sources and the obstacle slots.
// master drives game ticks, random value, level and slot releases; slave returns spawn controls.
interface obstacle_wave_scheduler_if #(
    parameter int NUM_SLOTS = 4
);
    logic                 game_en;
    logic [9:0]           rand_in;
    logic [7:0]           bank_level;
    logic [NUM_SLOTS-1:0] slot_done;
    logic [NUM_SLOTS-1:0] spawn;
    logic [9:0]           spawn_y;
    logic [9:0]           speed;
    logic [3:0]           wave;
    logic [NUM_SLOTS-1:0] slot_busy;
    logic                 stalled;

    modport master (
        output game_en, rand_in, bank_level, slot_done,
        input  spawn, spawn_y, speed, wave, slot_busy, stalled
    );

    modport slave (
        input  game_en, rand_in, bank_level, slot_done,
        output spawn, spawn_y, speed, wave, slot_busy, stalled
    );
endinterface

// File: rtl/obstacle_wave_scheduler.sv
// Purpose: round-robin obstacle spawner whose interval and speed tighten with bank_level.
// Latency: spawn pulse 2 clks after the tick that exhausts the interval, when a slot is free.
// Backpressure: with every slot busy it holds in STALL and retries each clk until one frees.
module obstacle_wave_scheduler #(
    parameter int         NUM_SLOTS      = 4,
    parameter logic [9:0] SPAWN_INTERVAL = 10'd40,
    parameter logic [9:0] MIN_INTERVAL   = 10'd10,
    parameter logic [9:0] INTERVAL_STEP  = 10'd4,
    parameter logic [9:0] BASE_SPEED     = 10'd5,
    parameter logic [9:0] MAX_SPEED      = 10'd12,
    parameter int         LEVEL_SHIFT    = 3,
    parameter logic [9:0] Y_MIN          = 10'd50,
    parameter logic [9:0] Y_RANGE        = 10'd200
) (
    input  logic                      clk,
    input  logic                      rst,
    obstacle_wave_scheduler_if.slave  bus
);

    localparam int         PW = $clog2(NUM_SLOTS);
    localparam logic [PW:0] NS = NUM_SLOTS[PW:0];

    typedef enum logic [2:0] {IDLE, COUNT, SELECT, STALL, SPAWN} state_t;

    state_t               state;
    logic [9:0]           count;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        slot_q;

    logic [7:0]           lvl_shifted;
    logic [3:0]           wave_nxt;
    logic [9:0]           speed_sum;
    logic [9:0]           speed_nxt;
    logic [13:0]          step_total;
    logic [9:0]           interval;
    logic [9:0]           r_ext;
    logic [9:0]           y_nxt;
    logic                 found;
    logic [PW-1:0]        sel_idx;
    logic [PW:0]          cand;
    logic [PW:0]          nxt_sum;
    logic [PW-1:0]        rr_nxt;
    logic [NUM_SLOTS-1:0] sel_onehot;
    logic [NUM_SLOTS-1:0] slot_onehot;
    logic [NUM_SLOTS-1:0] busy_nxt;

    assign lvl_shifted = bus.bank_level >> LEVEL_SHIFT;
    assign wave_nxt    = (lvl_shifted > 8'd15) ? 4'd15 : lvl_shifted[3:0];
    assign speed_sum   = BASE_SPEED + {6'd0, bus.wave};
    assign speed_nxt   = (speed_sum > MAX_SPEED) ? MAX_SPEED : speed_sum;

    // Compare before subtracting so a deep wave can never wrap the interval.
    assign step_total  = {4'd0, INTERVAL_STEP} * {10'd0, bus.wave};
    assign interval    = (step_total >= {4'd0, SPAWN_INTERVAL - MIN_INTERVAL}) ?
                         MIN_INTERVAL : (SPAWN_INTERVAL - step_total[9:0]);

    // Only the low byte of the random word feeds the Y fold; the mask drops the rest.
    assign r_ext = bus.rand_in & 10'h0FF;
    assign y_nxt = Y_MIN + ((r_ext >= Y_RANGE) ? (r_ext - Y_RANGE) : r_ext);

    // First free slot at or after rr_ptr, wrapping; uses the pre-release occupancy map.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cand = {1'b0, rr_ptr} + i[PW:0];
            if (cand >= NS) begin
                cand = cand - NS;
            end
            if (!found && !bus.slot_busy[cand[PW-1:0]]) begin
                found   = 1'b1;
                sel_idx = cand[PW-1:0];
            end
        end
    end

    assign nxt_sum     = {1'b0, slot_q} + {{PW{1'b0}}, 1'b1};
    assign rr_nxt      = (nxt_sum >= NS) ? '0 : nxt_sum[PW-1:0];
    assign sel_onehot  = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << sel_idx;
    assign slot_onehot = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << slot_q;
    assign busy_nxt    = (bus.slot_busy & ~bus.slot_done) |
                         ((state == SPAWN) ? slot_onehot : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            count         <= '0;
            rr_ptr        <= '0;
            slot_q        <= '0;
            bus.spawn     <= '0;
            bus.spawn_y   <= Y_MIN;
            bus.speed     <= BASE_SPEED;
            bus.wave      <= '0;
            bus.slot_busy <= '0;
            bus.stalled   <= 1'b0;
        end else begin
            bus.wave      <= wave_nxt;
            bus.speed     <= speed_nxt;
            bus.slot_busy <= busy_nxt;
            bus.spawn     <= '0;
            case (state)
                IDLE: begin
                    if (bus.game_en) begin
                        count <= interval;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (bus.game_en) begin
                        if (count == 10'd1) begin
                            state <= SELECT;
                        end else begin
                            count <= count - 10'd1;
                        end
                    end
                end
                SELECT, STALL: begin
                    if (found) begin
                        slot_q      <= sel_idx;
                        bus.spawn   <= sel_onehot;
                        bus.spawn_y <= y_nxt;
                        bus.stalled <= 1'b0;
                        state       <= SPAWN;
                    end else begin
                        bus.stalled <= 1'b1;
                        state       <= STALL;
                    end
                end
                SPAWN: begin
                    rr_ptr      <= rr_nxt;
                    count       <= interval;
                    bus.stalled <= 1'b0;
                    state       <= COUNT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_wave_scheduler.sv
// Bench for obstacle_wave_scheduler: tick-level reference model compared every cycle,
// plus hand-computed spawn slots, timings and Y values.
module tb_obstacle_wave_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    obstacle_wave_scheduler_if #(.NUM_SLOTS(4)) ifc();

    obstacle_wave_scheduler #(.NUM_SLOTS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int tick_cyc[$];
    int sp_cyc[$];
    int sp_val[$];
    int sp_y[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: counts ticks since the last reload; a search runs the clk after the
    // interval is used up and keeps retrying while all slots are occupied.
    bit [3:0] m_busy = 0, m_spawn = 0;
    bit       m_started = 0, m_search = 0, m_spawn_now = 0, m_stalled = 0;
    int       m_rr = 0, m_slot = 0, m_ticks = 0, m_y = 50, m_wave = 0, m_speed = 5;

    always @(posedge clk or negedge rst) begin : model
        int intv, nw, pick, j, r;
        bit [3:0] nb;
        if (!rst) begin
            m_busy = 0; m_spawn = 0; m_started = 0; m_search = 0; m_spawn_now = 0;
            m_stalled = 0; m_rr = 0; m_slot = 0; m_ticks = 0; m_y = 50; m_wave = 0; m_speed = 5;
        end else begin
            intv = (4 * m_wave >= 30) ? 10 : 40 - 4 * m_wave;
            nb   = m_busy & ~ifc.slot_done;
            if (m_spawn_now) begin
                nb[m_slot]  = 1'b1;
                m_rr        = (m_slot + 1) % 4;
                m_ticks     = intv;
                m_spawn_now = 0;
                m_stalled   = 0;
            end else if (m_search) begin
                pick = -1;
                for (int k = 0; k < 4; k++) begin
                    j = (m_rr + k) % 4;
                    if (pick < 0 && !m_busy[j]) pick = j;
                end
                if (pick >= 0) begin
                    r           = int'(ifc.rand_in[7:0]);
                    m_slot      = pick;
                    m_y         = 50 + ((r >= 200) ? r - 200 : r);
                    m_spawn_now = 1;
                    m_search    = 0;
                    m_stalled   = 0;
                end else begin
                    m_stalled = 1;
                end
            end else if (ifc.game_en) begin
                if (!m_started) begin
                    m_started = 1;
                    m_ticks   = intv;
                end else begin
                    m_ticks--;
                    if (m_ticks == 0) m_search = 1;
                end
            end
            m_busy  = nb;
            m_spawn = m_spawn_now ? (4'b0001 << m_slot) : 4'b0000;
            nw      = int'(ifc.bank_level) >> 3;
            if (nw > 15) nw = 15;
            m_speed = (5 + m_wave > 12) ? 12 : 5 + m_wave;
            m_wave  = nw;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("spawn", ifc.spawn, m_spawn);
            chk("slot_busy", ifc.slot_busy, m_busy);
            chk("stalled", ifc.stalled, m_stalled);
            chk("wave", ifc.wave, m_wave);
            chk("speed", ifc.speed, m_speed);
            if (m_spawn != 0) chk("spawn_y", ifc.spawn_y, m_y);
            if (ifc.spawn != 0) begin
                sp_cyc.push_back(cyc);
                sp_val.push_back(int'(ifc.spawn));
                sp_y.push_back(int'(ifc.spawn_y));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        for (int t = 0; t < n; t++) begin
            step();
            ifc.game_en = 1'b1;
            tick_cyc.push_back(cyc);
            step();
            ifc.game_en = 1'b0;
            step();
            step();
        end
    endtask

    task automatic pulse(input logic [3:0] mask, output int pc);
        step();
        ifc.slot_done = mask;
        pc = cyc;
        step();
        ifc.slot_done = 4'b0000;
    endtask

    task automatic chk_spawn(input int k, input int v, input int c, input int y);
        if (sp_val.size() <= k) begin
            n_chk++;
            n_fail++;
            $display("FAIL spawn%0d: missing, required value %0d at cycle %0d", k, v, c);
        end else begin
            chk($sformatf("spawn%0d_val", k), sp_val[k], v);
            chk($sformatf("spawn%0d_cycle", k), sp_cyc[k], c);
            chk($sformatf("spawn%0d_y", k), sp_y[k], y);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_spawn"}, ifc.spawn, 0);
        chk({tag, "_spawn_y"}, ifc.spawn_y, 50);
        chk({tag, "_speed"}, ifc.speed, 5);
        chk({tag, "_wave"}, ifc.wave, 0);
        chk({tag, "_busy"}, ifc.slot_busy, 0);
        chk({tag, "_stalled"}, ifc.stalled, 0);
    endtask

    initial begin
        int p, n0, n1, n2;
        ifc.game_en    = 1'b0;
        ifc.rand_in    = 10'd230;
        ifc.bank_level = 8'd0;
        ifc.slot_done  = 4'b0000;
        rst            = 1'b0;
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b1;
        repeat (20) step();
        chk("idle_no_spawn", sp_cyc.size(), 0);

        // Fill all four slots, then let a fifth interval expire into a stall.
        run_ticks(41);
        ifc.rand_in = 10'd100;
        run_ticks(40);
        ifc.rand_in = 10'd255;
        run_ticks(40);
        ifc.rand_in = 10'h3C8;
        run_ticks(40);
        run_ticks(40);
        chk("stall_flag", ifc.stalled, 1);
        chk("busy_full", ifc.slot_busy, 15);
        chk("spawns_before_stall", sp_cyc.size(), 4);
        chk_spawn(0, 1, tick_cyc[40] + 2, 80);
        chk_spawn(1, 2, tick_cyc[80] + 2, 150);
        chk_spawn(2, 4, tick_cyc[120] + 2, 105);
        chk_spawn(3, 8, tick_cyc[160] + 2, 50);

        ifc.bank_level = 8'd40;
        ifc.rand_in    = 10'd199;
        repeat (3) step();
        chk("wave_lvl40", ifc.wave, 5);
        chk("speed_lvl40", ifc.speed, 10);
        chk("still_stalled", ifc.stalled, 1);

        pulse(4'b0100, p);
        repeat (3) step();
        chk_spawn(4, 4, p + 2, 249);
        chk("busy_after_unstall", ifc.slot_busy, 15);
        chk("stall_cleared", ifc.stalled, 0);

        ifc.bank_level = 8'd255;
        repeat (3) step();
        chk("wave_lvl255", ifc.wave, 15);
        chk("speed_lvl255", ifc.speed, 12);

        // Second release of slot 0 lands on an idle slot and must change nothing.
        pulse(4'b0001, p);
        pulse(4'b0001, p);
        pulse(4'b0010, p);
        step();
        chk("busy_after_release", ifc.slot_busy, 12);

        // Count loaded at wave 5 (20) is not retimed by the jump to wave 15.
        ifc.rand_in = 10'd128;
        n0 = tick_cyc.size();
        run_ticks(20);
        chk_spawn(5, 1, tick_cyc[n0 + 19] + 2, 178);

        ifc.rand_in = 10'd7;
        n1 = tick_cyc.size();
        run_ticks(10);
        chk_spawn(6, 2, tick_cyc[n1 + 9] + 2, 57);

        pulse(4'b1000, p);
        n2 = tick_cyc.size();
        run_ticks(5);
        repeat (1000) step();
        chk("pause_no_spawn", sp_cyc.size(), 7);
        run_ticks(5);
        chk_spawn(7, 8, tick_cyc[n2 + 9] + 2, 57);

        run_ticks(10);
        chk("stall_before_reset", ifc.stalled, 1);
        step();
        rst = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        repeat (2) step();
        rst = 1'b1;
        repeat (10) step();
        chk("total_spawns", sp_cyc.size(), 8);
        chk("busy_after_reset", ifc.slot_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
